// File: rtl/rot_pkg.sv
// rot_pkg: shared frame geometry, default pixel width and packer FSM states.
package rot_pkg;
    localparam int IMG_DIM = 256;
    localparam int COORD_W = 8;
    localparam int DEF_PIX_W = 24;
    localparam logic [COORD_W-1:0] CMAX = COORD_W'(IMG_DIM - 1);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN, DONE} state_t;
endpackage

// File: rtl/rot_fifo.sv
// rot_fifo: first-word-fall-through FIFO; head reads as zero while empty.
module rot_fifo #(
    parameter int DEPTH = 16,
    parameter int W = 26
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic [$clog2(DEPTH):0]   fill
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);
    logic [W-1:0] mem [DEPTH];
    logic [AW:0] wr, rd;
    always_ff @(posedge clk)
        if (push) mem[wr[AW-1:0]] <= din;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr <= '0;
            rd <= '0;
        end else begin
            if (push) wr <= wr + ONE;
            if (pop) rd <= rd + ONE;
        end
    end
    assign fill = wr - rd;
    assign dout = (fill != '0) ? mem[rd[AW-1:0]] : '0;
endmodule

// File: rtl/rot_stream_packer.sv
// rot_stream_packer: packs a 256x256 rotated pixel stream into a valid/ready FIFO with sof/eol tags.
// Optional per-line byte-XOR checksum enabled by defining PACKER_LINE_SUM_EN.
module rot_stream_packer
    import rot_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PIX_W = DEF_PIX_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [PIX_W-1:0]         in_data,
    input  logic                     in_eol,
    input  logic                     clr_err,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PIX_W-1:0]         out_data,
    output logic                     out_sof,
    output logic                     out_eol,
    output logic                     frame_done,
    output logic                     ovf,
    output logic                     sync_err,
    output logic [$clog2(DEPTH):0]   fill,
    output logic [7:0]               line_sum,
    output logic                     line_sum_valid
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    state_t state, nxt;
    logic [COORD_W-1:0] col, row;
    logic acc_ok, last_px, pop, push, ovf_set, sync_set;
    logic [PIX_W+1:0] head;
    assign acc_ok = in_valid && (state == IDLE || state == STREAM);
    assign last_px = (col == CMAX) && (row == CMAX);
    assign pop = out_valid && out_ready;
    assign push = acc_ok && (fill != FULL || pop);
    assign ovf_set = acc_ok && !push;
    assign sync_set = (acc_ok && (in_eol != (col == CMAX))) || (in_valid && !acc_ok);
    rot_fifo #(.DEPTH(DEPTH), .W(PIX_W + 2)) u_fifo (
        .clk(clk), .rst(rst), .push(push), .pop(pop),
        .din({row == '0 && col == '0, col == CMAX, in_data}),
        .dout(head), .fill(fill)
    );
    assign out_valid = fill != '0;
    assign {out_sof, out_eol, out_data} = head;
    assign frame_done = state == DONE;
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (in_valid) nxt = last_px ? DRAIN : STREAM;
            STREAM:  if (in_valid && last_px) nxt = DRAIN;
            DRAIN:   if (fill == '0) nxt = DONE;
            default: nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            col <= '0;
            row <= '0;
            ovf <= 1'b0;
            sync_err <= 1'b0;
        end else begin
            state <= nxt;
            if (acc_ok) begin
                col <= col + 1'b1;
                if (col == CMAX) row <= row + 1'b1;
            end
            ovf <= ovf_set || (ovf && !clr_err);
            sync_err <= sync_set || (sync_err && !clr_err);
        end
    end
`ifdef PACKER_LINE_SUM_EN
    logic [7:0] acc, beat_x;
    always_comb begin
        beat_x = '0;
        for (int i = 0; i < PIX_W / 8; i++) beat_x = beat_x ^ out_data[8*i +: 8];
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
            line_sum <= '0;
            line_sum_valid <= 1'b0;
        end else begin
            line_sum_valid <= pop && out_eol;
            if (pop) acc <= out_eol ? '0 : acc ^ beat_x;
            if (pop && out_eol) line_sum <= acc ^ beat_x;
        end
    end
`else
    assign line_sum = '0;
    assign line_sum_valid = 1'b0;
`endif
endmodule

// File: tb/tb_rot_stream_packer.sv
// tb_rot_stream_packer: directed self-checking bench for rot_stream_packer (DEPTH=16, PIX_W=24).
module tb_rot_stream_packer;
    logic clk = 0, rst = 1;
    logic in_valid = 0, in_eol = 0, clr_err = 0, out_ready = 0;
    logic [23:0] in_data = '0;
    logic out_valid, out_sof, out_eol, frame_done, ovf, sync_err, line_sum_valid;
    logic [23:0] out_data;
    logic [4:0] fill;
    logic [7:0] line_sum;
    int errors = 0, checks = 0, k = 0, fd_cnt = 0;

    rot_stream_packer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_eol(in_eol),
        .clr_err(clr_err), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sof(out_sof), .out_eol(out_eol), .frame_done(frame_done), .ovf(ovf),
        .sync_err(sync_err), .fill(fill), .line_sum(line_sum), .line_sum_valid(line_sum_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1;
        in_valid = 0;
        in_eol = 0;
        clr_err = 0;
        #2;
        rst = 0;
    endtask

    task automatic sample();
        if (frame_done) fd_cnt++;
        if (out_valid && out_ready) begin
            check("beat", {out_sof, out_eol, out_data}, {k == 0, k % 256 == 255, k[15:0], 8'h00});
            k++;
        end
    endtask

    task automatic push_px(input int col, input logic [23:0] d, input logic eol);
        in_valid = 1;
        in_data = d;
        in_eol = eol;
        tick();
        in_valid = 0;
        in_eol = 0;
    endtask

    initial begin
        tick();
        tick();
        check("rst_outs", {out_valid, out_sof, out_eol, frame_done, ovf, sync_err, line_sum_valid},
              7'd0);
        check("rst_fill", fill, 0);
        check("rst_data", out_data, 0);
        check("rst_sum", line_sum, 0);
        do_reset();

        // full frame, always ready
        out_ready = 1;
        for (int i = 0; i < 65536; i++) begin
            in_valid = 1;
            in_data = {i[15:8], i[7:0], 8'h00};
            in_eol = i[7:0] == 8'hFF;
            sample();
            tick();
        end
        in_valid = 0;
        in_eol = 0;
        for (int t = 0; t < 10; t++) begin
            sample();
            tick();
        end
        check("frame_beats", k, 65536);
        check("frame_done_cnt", fd_cnt, 1);
        check("frame_ovf", ovf, 0);
        check("frame_sync", sync_err, 0);
        check("frame_fill", fill, 0);

        // overflow: 20 pixels into a stalled 16-deep FIFO
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 20; i++) begin
            push_px(i, 24'h100 + 24'(i), 0);
            if (i == 0) check("fwft", {out_valid, out_data}, {1'b1, 24'h100});
        end
        check("ovf_fill", fill, 16);
        check("ovf_flag", ovf, 1);
        check("ovf_sync", sync_err, 0);
        out_ready = 1;
        for (int j = 0; j < 16; j++) begin
            check("ovf_drain", {out_valid, out_data}, {1'b1, 24'h100 + 24'(j)});
            tick();
        end
        check("ovf_empty", {out_valid, fill}, 0);

        // push and pop while full
        do_reset();
        out_ready = 0;
        for (int i = 0; i < 16; i++) push_px(i, 24'h200 + 24'(i), 0);
        check("full_fill", fill, 16);
        out_ready = 1;
        push_px(16, 24'h210, 0);
        check("full_pp_fill", fill, 16);
        check("full_pp_ovf", ovf, 0);
        for (int j = 1; j <= 16; j++) begin
            check("full_pp_drain", out_data, 24'h200 + 24'(j));
            tick();
        end
        check("full_pp_empty", fill, 0);

        // eol misalignment and clear
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 100; i++) push_px(i, 24'(i), 0);
        check("sync_pre", sync_err, 0);
        push_px(100, 24'd100, 1);
        check("sync_set", sync_err, 1);
        clr_err = 1;
        tick();
        clr_err = 0;
        check("sync_clr", sync_err, 0);
        clr_err = 1;
        push_px(101, 24'd101, 1);
        clr_err = 0;
        check("sync_win", sync_err, 1);
        clr_err = 1;
        tick();
        clr_err = 0;
        check("sync_clr2", sync_err, 0);
        check("sync_ovf", ovf, 0);

        // reset mid-frame at row 3 col 40 with 9 queued
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 800; i++) push_px(i, 24'(i), i[7:0] == 8'hFF);
        out_ready = 0;
        for (int i = 800; i < 808; i++) push_px(i, 24'(i), 0);
        check("mid_fill", fill, 9);
        rst = 1;
        #1;
        check("mid_rst_outs", {out_valid, out_sof, out_eol, frame_done, ovf, sync_err, line_sum_valid},
              7'd0);
        check("mid_rst_fill", fill, 0);
        check("mid_rst_data", out_data, 0);
        rst = 0;
        out_ready = 1;
        push_px(0, 24'hABCDEF, 0);
        check("mid_sof", {out_valid, out_sof, out_eol, out_data}, {3'b110, 24'hABCDEF});

        // one line with only col 0 = 0000FF
        do_reset();
        out_ready = 1;
        for (int i = 0; i < 256; i++) push_px(i, (i == 0) ? 24'h0000FF : 24'h0, i == 255);
        check("ls_eol_beat", {out_valid, out_eol}, 2'b11);
        check("ls_pre", line_sum_valid, 0);
        tick();
`ifdef PACKER_LINE_SUM_EN
        check("ls_valid", line_sum_valid, 1);
        check("ls_value", line_sum, 8'hFF);
`else
        check("ls_valid", line_sum_valid, 0);
        check("ls_value", line_sum, 0);
`endif
        tick();
        check("ls_post", line_sum_valid, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rot_stream_packer.md
ROT_STREAM_PACKER -- requirements
Module: rot_stream_packer

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries (power of two, 4..256).
REQ-002 SHALL have parameter PIX_W, default 24, pixel width (8-bit RGB).
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_valid  input  1  pixel from the rotation stage is present this cycle; no backpressure upstream.
REQ-006 in_data  input  PIX_W  rotated pixel.
REQ-007 in_eol  input  1  upstream last-pixel-of-line marker.
REQ-008 clr_err  input  1  synchronous clear of sticky error flags.
REQ-009 out_valid / out_ready  output / input  1 / 1  downstream valid-ready handshake; beat transfers when both high.
REQ-010 out_data  output  PIX_W  head pixel.
REQ-011 out_sof / out_eol  output  1 / 1  beat is first of frame / last of a 256-pixel line.
REQ-012 frame_done  output  1  one-cycle pulse when a full frame has left the block.
REQ-013 ovf / sync_err  output  1 / 1  sticky: pixel dropped / in_eol misaligned.
REQ-014 fill  output  log2(DEPTH)+1  current FIFO occupancy.
REQ-015 line_sum / line_sum_valid  output  8 / 1  per-line checksum (see Configuration).

Function
REQ-016 Frame SHALL be 256x256 pixels; 8-bit col and row counters advance on each accepted in_valid, col wrapping 255->0 and incrementing row.
REQ-017 FSM states IDLE, STREAM, DRAIN, DONE: IDLE->STREAM on first in_valid; STREAM->DRAIN when pixel (255,255) is accepted; DRAIN->DONE when FIFO empty; DONE->IDLE after one cycle, frame_done=1 only in DONE.
REQ-018 Each FIFO entry SHALL store {sof, eol, pixel}; sof=1 iff row=0 and col=0, eol=1 iff col=255, both computed from internal counters, not in_eol.
REQ-019 Write SHALL occur when in_valid and (fill<DEPTH or a pop occurs the same cycle); otherwise the pixel is dropped, ovf set, counters still advance.
REQ-020 FIFO SHALL be first-word-fall-through: pixel written in cycle N visible on out_data in cycle N+1 when FIFO was empty.
REQ-021 out_valid SHALL equal fill!=0; out_data/out_sof/out_eol hold stable while out_valid and not out_ready.
REQ-022 Simultaneous push and pop SHALL leave fill unchanged, including at fill=DEPTH and fill=1.
REQ-023 sync_err SHALL set when in_valid and in_eol differs from (col==255); in_valid in DRAIN/DONE SHALL be ignored and set sync_err.
REQ-024 clr_err SHALL clear ovf and sync_err next edge; a same-cycle new error wins over clear.
REQ-025 Pointers SHALL be log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.

Reset
REQ-026 On rst: FSM=IDLE, counters, pointers, fill=0; out_valid, out_sof, out_eol, frame_done, ovf, sync_err, line_sum, line_sum_valid=0; out_data=0 (FIFO RAM not cleared).
REQ-027 rst mid-frame SHALL discard FIFO contents; the next accepted pixel is (0,0) with sof=1.

Configuration
REQ-028 Macro PACKER_LINE_SUM_EN: when defined, line_sum SHALL be XOR of all three bytes of every transferred beat of a line, presented with line_sum_valid=1 for one cycle after the eol beat transfers, accumulator then restarts at 0.
REQ-029 Without PACKER_LINE_SUM_EN, ports SHALL remain present and be tied 0; no accumulator logic.

Structure
REQ-030 Shared package rot_pkg SHALL hold IMG_DIM=256, COORD_W=8, PIX_W default and the FSM state enum.
REQ-031 FIFO SHALL be sub-module rot_fifo (storage, pointers, fill); FSM, counters, flags, checksum in top.

Verification
REQ-032 out_ready=1, 65536 pixels data={row,col,8'h00} with correct in_eol -> identical output order, sof on beat 0 only, eol every 256th beat, frame_done one pulse after last beat, ovf=sync_err=0.
REQ-033 out_ready=0, 20 consecutive pixels, DEPTH=16 -> fill=16, ovf=1, pixels 16..19 dropped; then out_ready=1 drains pixels 0..15 in order.
REQ-034 fill=16, in_valid and out_ready same cycle -> write accepted, fill stays 16, ovf stays 0.
REQ-035 in_eol=1 at col 100 -> sync_err=1 next cycle; clr_err pulse -> 0.
REQ-036 rst at row 3 col 40 with fill=9 -> all outputs 0 next cycle; next pixel emerges with out_sof=1.
REQ-037 PACKER_LINE_SUM_EN defined, line with col0=24'h0000FF, others 0 -> line_sum=8'hFF, line_sum_valid one cycle after eol beat.
